// File: rtl/alu_arbiter.sv
//------------------------------------------------------------------------------
// alu_arbiter
//   Shares one multi-cycle ALU between NUM_REQ valid/ready requesters.
//   Grants one request at a time, holds the operands on the ALU for ALU_LAT
//   cycles, then returns result and flag to the winner as a one-cycle pulse.
//   Optional: define ALU_ARB_FIXED_PRIO_EN for lowest-index-wins priority
//   instead of the default round-robin.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module alu_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ*2-1:0]   req_op,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [WIDTH-1:0]       rsp_data,
  output logic                   rsp_flag,
  output logic                   busy,
  output logic [WIDTH-1:0]       alu_a,
  output logic [WIDTH-1:0]       alu_b,
  output logic [1:0]             alu_op,
  input  logic [WIDTH-1:0]       alu_out,
  input  logic                   alu_flag
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(ALU_LAT + 1);
  localparam logic [PTR_W:0]   NREQ_EXT = (PTR_W+1)'(NUM_REQ);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ALU_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   wait_q, wait_d;
  logic [WIDTH-1:0]   opa_q, opb_q;
  logic [1:0]         op_q;
  logic [PTR_W-1:0]   gnt_q;
  logic [NUM_REQ-1:0] rsp_valid_q;
  logic [WIDTH-1:0]   rsp_data_q;
  logic               rsp_flag_q;

  logic               grant_found;
  logic [PTR_W-1:0]   grant_idx;
  logic [PTR_W:0]     idx_sum;
  logic [WIDTH-1:0]   sel_a, sel_b;
  logic [1:0]         sel_op;
  logic               accept;

`ifndef ALU_ARB_FIXED_PRIO_EN
  logic [PTR_W-1:0]   rr_ptr_q;
`endif

  // Grant search: first valid requester at or above the start point, wrapping.
  // An X on req_valid fails the if-test, so an unknown bit never wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    idx_sum     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      idx_sum = (PTR_W+1)'(i);
`else
      idx_sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(i);
      if (idx_sum >= NREQ_EXT) idx_sum = idx_sum - NREQ_EXT;
`endif
      if (!grant_found && req_valid[idx_sum[PTR_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = idx_sum[PTR_W-1:0];
      end
    end
  end

  // Operand mux for the winning requester.
  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = 2'b00;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (grant_idx == PTR_W'(j)) begin
        sel_a  = req_a[j*WIDTH +: WIDTH];
        sel_b  = req_b[j*WIDTH +: WIDTH];
        sel_op = req_op[j*2 +: 2];
      end
    end
  end

  assign accept = (state_q == S_IDLE) && grant_found;

  // Ready is combinational in IDLE; gated by rst so it stays low during reset.
  always_comb begin
    req_ready = '0;
    if (accept && rst) req_ready[grant_idx] = 1'b1;
  end

  // Next-state logic: IDLE -> EXEC on accept, EXEC for ALU_LAT cycles, DONE for one.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      S_IDLE: begin
        wait_d = '0;
        if (grant_found) state_d = S_EXEC;
      end
      S_EXEC: begin
        if (wait_q == LAST_CNT) begin
          wait_d  = '0;
          state_d = S_DONE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and latency counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Operand capture on accept and response capture leaving DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      opa_q       <= '0;
      opb_q       <= '0;
      op_q        <= 2'b00;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_flag_q  <= 1'b0;
    end else begin
      rsp_valid_q <= '0;
      if (accept) begin
        opa_q <= sel_a;
        opb_q <= sel_b;
        op_q  <= sel_op;
        gnt_q <= grant_idx;
      end
      if (state_q == S_DONE) begin
        rsp_valid_q <= {{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_q;
        rsp_data_q  <= alu_out;
        rsp_flag_q  <= alu_flag;
      end
    end
  end

`ifndef ALU_ARB_FIXED_PRIO_EN
  // Round-robin pointer moves just past the most recent winner.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q <= '0;
    end else if (accept) begin
      rr_ptr_q <= (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
    end
  end
`endif

  // ALU operands follow the operand registers, so they simply hold while idle.
  assign alu_a     = opa_q;
  assign alu_b     = opb_q;
  assign alu_op    = (state_q == S_IDLE) ? 2'b00 : op_q;
  assign busy      = (state_q != S_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_flag  = rsp_flag_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
//------------------------------------------------------------------------------
// tb_alu_arbiter
//   Directed bench for alu_arbiter with a behavioural one-cycle ALU.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_alu_arbiter;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 4;
  localparam int ALU_LAT = 1;

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic [NUM_REQ-1:0]       req_valid = '0;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a = '0;
  logic [NUM_REQ*WIDTH-1:0] req_b = '0;
  logic [NUM_REQ*2-1:0]     req_op = '0;
  logic [NUM_REQ-1:0]       rsp_valid;
  logic [WIDTH-1:0]         rsp_data;
  logic                     rsp_flag;
  logic                     busy;
  logic [WIDTH-1:0]         alu_a, alu_b;
  logic [1:0]               alu_op;
  logic [WIDTH-1:0]         alu_out;
  logic                     alu_flag;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .ALU_LAT(ALU_LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_flag(rsp_flag),
    .busy(busy),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_out(alu_out), .alu_flag(alu_flag)
  );

  // Stand-in ALU, one cycle latency: 00 off, 01 add (carry), 10 sub (borrow), 11 pass A.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_out  <= '0;
      alu_flag <= 1'b0;
    end else begin
      case (alu_op)
        2'b01:   {alu_flag, alu_out} <= {1'b0, alu_a} + {1'b0, alu_b};
        2'b10:   {alu_flag, alu_out} <= {1'b0, alu_a} - {1'b0, alu_b};
        2'b11:   {alu_flag, alu_out} <= {1'b0, alu_a};
        default: {alu_flag, alu_out} <= '0;
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int idx, input logic [3:0] a, input logic [3:0] b,
                         input logic [1:0] op);
    req_a[idx*WIDTH +: WIDTH] = a;
    req_b[idx*WIDTH +: WIDTH] = b;
    req_op[idx*2 +: 2]        = op;
  endtask

  function automatic logic [31:0] oh(input int idx);
    logic [31:0] v;
    v = 32'd1 << idx;
    return v;
  endfunction

  typedef struct {
    int         idx;
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] op;
    int         oth;     // requester raised during EXEC, -1 for none
    logic [3:0] exp_d;
    logic       exp_f;
  } vec_t;

  vec_t vecs[8];
  int   exp_order[5];

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{0, 4'h9, 4'h8, 2'b01, -1, 4'h1, 1'b1};
    vecs[1] = '{2, 4'h3, 4'h5, 2'b10,  1, 4'hE, 1'b1};
    vecs[2] = '{1, 4'h7, 4'h2, 2'b01, -1, 4'h9, 1'b0};
    vecs[3] = '{3, 4'h5, 4'h3, 2'b10,  0, 4'h2, 1'b0};
    vecs[4] = '{1, 4'hF, 4'h1, 2'b01, -1, 4'h0, 1'b1};
    vecs[5] = '{0, 4'h6, 4'h2, 2'b00, -1, 4'h0, 1'b0};
    vecs[6] = '{3, 4'h4, 4'h4, 2'b11, -1, 4'h4, 1'b0};
    vecs[7] = '{2, 4'hA, 4'hC, 2'b10, -1, 4'hE, 1'b1};
`ifdef ALU_ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0, 0};
`else
    exp_order = '{0, 1, 2, 3, 0};
`endif

    // Reset held with every requester valid: everything quiet.
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 4'(i + 1), 4'h1, 2'b01);
`ifdef ALU_ARB_FIXED_PRIO_EN
    req_valid = 4'b1001;
`else
    req_valid = 4'b1111;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_data", 32'(rsp_data), 0);
    chk("rst_rsp_flag", 32'(rsp_flag), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_alu_op", 32'(alu_op), 0);
    chk("rst_alu_a", 32'(alu_a), 0);
    chk("rst_alu_b", 32'(alu_b), 0);
    tick();
    rst = 1'b1;

    // Continuous requests: grant order and back-to-back accept on each response.
    for (int g = 0; g < 5; g++) begin
      @(negedge clk);
      chk($sformatf("rr_grant%0d", g), 32'(req_ready), oh(exp_order[g]));
      if (g > 0) begin
        chk($sformatf("rr_rsp_valid%0d", g), 32'(rsp_valid), oh(exp_order[g-1]));
        chk($sformatf("rr_rsp_data%0d", g), 32'(rsp_data), 32'(exp_order[g-1] + 2));
        chk($sformatf("rr_busy_low%0d", g), 32'(busy), 0);
      end
      tick();
      if (g == 4) req_valid = '0;
      @(negedge clk);
      chk($sformatf("rr_busy_e%0d", g), 32'(busy), 1);
      tick();
      @(negedge clk);
      chk($sformatf("rr_busy_d%0d", g), 32'(busy), 1);
      tick();
    end
    @(negedge clk);
    chk("rr_last_rsp_valid", 32'(rsp_valid), oh(exp_order[4]));
    chk("rr_last_rsp_data", 32'(rsp_data), 32'(exp_order[4] + 2));
    tick();

    // Single-requester vector table.
    for (int v = 0; v < 8; v++) begin
      set_req(vecs[v].idx, vecs[v].a, vecs[v].b, vecs[v].op);
      req_valid = '0;
      req_valid[vecs[v].idx] = 1'b1;
      @(negedge clk);
      chk($sformatf("v%0d_ready", v), 32'(req_ready), oh(vecs[v].idx));
      tick();
      req_valid = '0;
      if (vecs[v].oth >= 0) req_valid[vecs[v].oth] = 1'b1;
      @(negedge clk);
      chk($sformatf("v%0d_exec_op", v), 32'(alu_op), 32'(vecs[v].op));
      chk($sformatf("v%0d_exec_a", v), 32'(alu_a), 32'(vecs[v].a));
      chk($sformatf("v%0d_exec_b", v), 32'(alu_b), 32'(vecs[v].b));
      chk($sformatf("v%0d_exec_ready", v), 32'(req_ready), 0);
      chk($sformatf("v%0d_exec_busy", v), 32'(busy), 1);
      tick();
      @(negedge clk);
      chk($sformatf("v%0d_done_op", v), 32'(alu_op), 32'(vecs[v].op));
      chk($sformatf("v%0d_done_ready", v), 32'(req_ready), 0);
      tick();
      req_valid = '0;
      @(negedge clk);
      chk($sformatf("v%0d_rsp_valid", v), 32'(rsp_valid), oh(vecs[v].idx));
      chk($sformatf("v%0d_rsp_data", v), 32'(rsp_data), 32'(vecs[v].exp_d));
      chk($sformatf("v%0d_rsp_flag", v), 32'(rsp_flag), 32'(vecs[v].exp_f));
      chk($sformatf("v%0d_idle_op", v), 32'(alu_op), 0);
      tick();
      @(negedge clk);
      chk($sformatf("v%0d_pulse_end", v), 32'(rsp_valid), 0);
      chk($sformatf("v%0d_data_hold", v), 32'(rsp_data), 32'(vecs[v].exp_d));
      tick();
    end

    // Reset during EXEC discards the operation and clears the pointer.
    set_req(2, 4'h1, 4'h1, 2'b01);
    req_valid = 4'b0100;
    @(negedge clk);
    chk("mid_ready", 32'(req_ready), oh(2));
    tick();
    req_valid = '0;
    rst = 1'b0;
    #1;
    chk("mid_alu_op", 32'(alu_op), 0);
    chk("mid_busy", 32'(busy), 0);
    tick();
    tick();
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("mid_no_rsp%0d", c), 32'(rsp_valid), 0);
      tick();
    end
    set_req(1, 4'h2, 4'h3, 2'b01);
    set_req(3, 4'h7, 4'h7, 2'b01);
    req_valid = 4'b1010;
    @(negedge clk);
    chk("post_rst_grant", 32'(req_ready), oh(1));
    tick();
    req_valid = '0;
    tick();
    tick();
    @(negedge clk);
    chk("post_rst_rsp_valid", 32'(rsp_valid), oh(1));
    chk("post_rst_rsp_data", 32'(rsp_data), 32'h5);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one `my_alu` instance between NUM_REQ requesters, each with a valid/ready request port and a response pulse.
- Arbitrates among the requesters, registers the operands, drives the ALU and waits ALU_LAT cycles.
- Returns the ALU result and flag to the requester that won, with one operation in flight at a time.
- Sits between the requester blocks and the ALU; the ALU ports connect directly to `my_alu`'s A/B/alu_op/out/flag.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 4, operand and result width; must match the ALU.
- ALU_LAT, 1, ALU clock-to-result latency in cycles (>=1).

Ports:
- clk, input, 1, system clock; all logic is rising-edge.
- rst, input, 1, reset, asynchronous, active-low.
- req_valid, input, NUM_REQ, per-requester request valid.
- req_ready, output, NUM_REQ, per-requester accept strobe; at most one bit high.
- req_a, input, NUM_REQ*WIDTH, operand A; requester i uses slice [i*WIDTH +: WIDTH].
- req_b, input, NUM_REQ*WIDTH, operand B, sliced the same way.
- req_op, input, NUM_REQ*2, op code: 00 off, 01 add, 10 sub, 11 no-op.
- rsp_valid, output, NUM_REQ, one-cycle response pulse to the granted requester.
- rsp_data, output, WIDTH, result, valid while any rsp_valid bit is high.
- rsp_flag, output, 1, ALU flag, valid with rsp_data.
- busy, output, 1, high while an operation is in flight (EXEC or DONE state).
- alu_a, output, WIDTH, drives ALU A.
- alu_b, output, WIDTH, drives ALU B.
- alu_op, output, 2, drives ALU alu_op.
- alu_out, input, WIDTH, ALU result.
- alu_flag, input, 1, ALU carry/borrow flag.

Behaviour:
- Reset (rst=0, asynchronous) forces:
  - state IDLE, rr_ptr=0, wait counter=0;
  - req_ready=0, rsp_valid=0, rsp_data=0, rsp_flag=0, busy=0;
  - alu_a=0, alu_b=0, alu_op=2'b00.
- Reset mid-operation discards the operation: no response is ever issued for it.
- State IDLE:
  - alu_op=00 (ALU off). alu_a/alu_b hold their last values.
  - If any req_valid is set, the grant g is the first set bit searching upward from rr_ptr, wrapping modulo NUM_REQ.
  - req_ready[g]=1 combinationally in that same cycle; the transfer completes on that edge.
  - On that edge: latch req_a/b/op[g] into the operand registers, latch g, set rr_ptr=(g+1) mod NUM_REQ, go to EXEC.
- State EXEC:
  - alu_a/alu_b/alu_op are driven from the operand registers and held stable.
  - Stays for ALU_LAT cycles, then goes to DONE.
- State DONE:
  - ALU inputs are still held and alu_out/alu_flag are valid.
  - On the edge: rsp_data<=alu_out, rsp_flag<=alu_flag, rsp_valid[g]<=1; go to IDLE.
- Timing:
  - rsp_valid pulses for exactly 1 cycle, in cycle ALU_LAT+2 counted from the accept cycle (cycle 0).
  - rsp_data/rsp_flag hold their value until the next response.
- Back-to-back: a new request may be accepted in the same cycle a rsp_valid pulse is high. Peak throughput is one operation per ALU_LAT+2 cycles.
- Requester protocol: a requester holds req_valid and its operands stable until req_ready. Dropping valid before ready is legal; the request is simply not taken.
- req_ready=0 in EXEC and DONE regardless of req_valid.
- Ops 00 and 11 are sequenced like any other op. The arbiter never interprets results; alu_out and alu_flag are passed through unmodified.
- Fairness: round-robin guarantees that a continuously-valid requester is granted within NUM_REQ grants.
- X on req_valid bits: no grant from an X bit. Bench checks apply only to known values.

Optional Feature:
- Macro: ALU_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; the lowest-index valid requester always wins. rr_ptr is removed and starvation is permitted.
- Undefined (default): round-robin as described in Behaviour.

Test Plan:
- Reset: rst=0 with all req_valid=1 -> all outputs 0, alu_op=00, no req_ready. Release rst -> requester 0 granted first.
- Single add: req0 a=4'h9 b=4'h8 op=01 (ALU_LAT=1) -> req_ready[0] in cycle 0, alu_op=01 in cycles 1-2, rsp_valid[0] in cycle 3 with rsp_data=4'h1, rsp_flag=1.
- Round-robin: req0..req3 held valid continuously -> grant order 0,1,2,3,0. A new grant occurs in each rsp_valid cycle; busy toggles low for 1 cycle only.
- Sub plus lockout: req2 a=4'h3 b=4'h5 op=10 -> rsp_data=4'hE to req2 only. A req1 raised during EXEC sees no req_ready until IDLE.
- Mid-op reset: assert rst=0 during EXEC -> rsp_valid never pulses for that op, alu_op=00 immediately. After release the arbiter accepts again with rr_ptr=0.
- With ALU_ARB_FIXED_PRIO_EN: req0 and req3 held valid -> req0 granted every time and req3 never.
